uart_rx_frame_ctrl: RTL and testbench

Frame-level controller that sequences the UART byte receiver and turns its byte stream into framed commands for the LCD subsystem.
- Gates the receiver enable and hunts for a sync byte.
- Parses the frame SYNC, CMD, LEN, DATA[0..LEN-1], CHK.
- Writes payload bytes into an external frame buffer.
- Reports frame completion or error with single-cycle pulses.
- Sits between the UART receiver and the LCD command/character buffer.

---
 rtl/uart_rx_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller between the UART byte receiver and the LCD buffer:
// hunts for SYNC, parses CMD/LEN/DATA/CHK, writes the payload and flags done or error.
module uart_rx_frame_ctrl #(
    parameter int                      PAYLOAD_BITS   = 8,
    parameter int                      MAX_LEN        = 32,
    parameter logic [PAYLOAD_BITS-1:0] SYNC_BYTE      = PAYLOAD_BITS'(8'hA5),
    parameter int                      TIMEOUT_CYCLES = 270_000,
    parameter int                      USE_BREAK      = 0
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         ENABLE_I,
    output logic                         RX_EN_O,
    input  logic                         RX_VLD_I,
    input  logic [PAYLOAD_BITS-1:0]      RX_D_I,
    input  logic                         RX_BREAK_I,
    output logic [PAYLOAD_BITS-1:0]      CMD_O,
    output logic [$clog2(MAX_LEN+1)-1:0] LEN_O,
    output logic                         WR_EN_O,
    output logic [$clog2(MAX_LEN)-1:0]   WR_ADDR_O,
    output logic [PAYLOAD_BITS-1:0]      WR_DATA_O,
    output logic                         FRAME_DONE_O,
    output logic                         FRAME_ERR_O,
    output logic [1:0]                   ERR_CODE_O,
    output logic                         BUSY_O
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [PAYLOAD_BITS-1:0] MAX_LEN_B = PAYLOAD_BITS'(MAX_LEN);
    localparam logic [TMR_W-1:0]        TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [2:0] {StIdle, StHunt, StCmd, StLen, StData, StChk} state_t;

    state_t                    state_q, state_d;
    logic [PAYLOAD_BITS-1:0]   chk_q, chk_d;
    logic [PAYLOAD_BITS-1:0]   cmd_q, cmd_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [PAYLOAD_BITS-1:0]   cmd_out_q, cmd_out_d;
    logic [LEN_W-1:0]          len_out_q, len_out_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [PAYLOAD_BITS-1:0]   wr_data_q, wr_data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [1:0]                code_q, code_d;
    logic                      in_frame;

    assign in_frame = (state_q == StCmd) || (state_q == StLen) ||
                      (state_q == StData) || (state_q == StChk);

    always_comb begin
        state_d   = state_q;
        chk_d     = chk_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        timer_d   = (in_frame && !RX_VLD_I) ? timer_q + TMR_W'(1) : '0;
        cmd_out_d = cmd_out_q;
        len_out_d = len_out_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;

        if (!ENABLE_I) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StHunt;
                StHunt: begin
                    if (RX_VLD_I && RX_D_I == SYNC_BYTE) state_d = StCmd;
                end
                default: begin
                    // Timeout wins over a byte arriving in the same cycle.
                    if (timer_q == TMR_LAST) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TMO;
                        state_d = StHunt;
                        timer_d = '0;
                    end else if (RX_VLD_I && RX_BREAK_I && USE_BREAK != 0) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TMO;
                        state_d = StHunt;
                    end else if (RX_VLD_I) begin
                        unique case (state_q)
                            StCmd: begin
                                cmd_d   = RX_D_I;
                                chk_d   = RX_D_I;
                                state_d = StLen;
                            end
                            StLen: begin
                                if (RX_D_I > MAX_LEN_B) begin
                                    err_d   = 1'b1;
                                    code_d  = ERR_LEN;
                                    state_d = StHunt;
                                end else begin
                                    chk_d   = chk_q ^ RX_D_I;
                                    len_d   = RX_D_I[LEN_W-1:0];
                                    cnt_d   = '0;
                                    state_d = (RX_D_I == '0) ? StChk : StData;
                                end
                            end
                            StData: begin
                                chk_d     = chk_q ^ RX_D_I;
                                wr_en_d   = 1'b1;
                                wr_addr_d = cnt_q[ADDR_W-1:0];
                                wr_data_d = RX_D_I;
                                cnt_d     = cnt_q + LEN_W'(1);
                                if (cnt_q == len_q - LEN_W'(1)) state_d = StChk;
                            end
                            default: begin
                                if (RX_D_I == chk_q) begin
                                    done_d    = 1'b1;
                                    cmd_out_d = cmd_q;
                                    len_out_d = len_q;
                                end else begin
                                    err_d  = 1'b1;
                                    code_d = ERR_CHK;
                                end
                                state_d = StHunt;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= StIdle;
            chk_q     <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            cmd_out_q <= '0;
            len_out_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            chk_q     <= chk_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            cmd_out_q <= cmd_out_d;
            len_out_q <= len_out_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign RX_EN_O      = (state_q != StIdle);
    assign BUSY_O       = in_frame;
    assign CMD_O        = cmd_out_q;
    assign LEN_O        = len_out_q;
    assign WR_EN_O      = wr_en_q;
    assign WR_ADDR_O    = wr_addr_q;
    assign WR_DATA_O    = wr_data_q;
    assign FRAME_DONE_O = done_q;
    assign FRAME_ERR_O  = err_q;
    assign ERR_CODE_O   = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: one instance with break handling, one without,
// sharing the same stimulus.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rx_vld = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic       rx_break = 1'b0;

    logic       rx_en_a, wr_en_a, done_a, err_a, busy_a;
    logic [7:0] cmd_a, wr_data_a;
    logic [5:0] len_a;
    logic [4:0] wr_addr_a;
    logic [1:0] code_a;
    logic       rx_en_b, wr_en_b, done_b, err_b, busy_b;
    logic [7:0] cmd_b, wr_data_b;
    logic [5:0] len_b;
    logic [4:0] wr_addr_b;
    logic [1:0] code_b;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.TIMEOUT_CYCLES(50), .USE_BREAK(1)) dut_brk (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable), .RX_EN_O(rx_en_a),
        .RX_VLD_I(rx_vld), .RX_D_I(rx_d), .RX_BREAK_I(rx_break),
        .CMD_O(cmd_a), .LEN_O(len_a), .WR_EN_O(wr_en_a), .WR_ADDR_O(wr_addr_a),
        .WR_DATA_O(wr_data_a), .FRAME_DONE_O(done_a), .FRAME_ERR_O(err_a),
        .ERR_CODE_O(code_a), .BUSY_O(busy_a)
    );

    uart_rx_frame_ctrl #(.TIMEOUT_CYCLES(50), .USE_BREAK(0)) dut_nb (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable), .RX_EN_O(rx_en_b),
        .RX_VLD_I(rx_vld), .RX_D_I(rx_d), .RX_BREAK_I(rx_break),
        .CMD_O(cmd_b), .LEN_O(len_b), .WR_EN_O(wr_en_b), .WR_ADDR_O(wr_addr_b),
        .WR_DATA_O(wr_data_b), .FRAME_DONE_O(done_b), .FRAME_ERR_O(err_b),
        .ERR_CODE_O(code_b), .BUSY_O(busy_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse counters and write logs, sampled mid-cycle.
    int          wr_n_a = 0, wr_n_b = 0, done_n_a = 0, done_n_b = 0;
    int          err_n_a = 0, err_n_b = 0, overlap_n = 0;
    logic [15:0] log_a [0:63];
    logic [15:0] log_b [0:63];

    always @(negedge clk) begin
        if (wr_en_a) begin
            log_a[wr_n_a % 64] <= {3'b000, wr_addr_a, wr_data_a};
            wr_n_a <= wr_n_a + 1;
        end
        if (wr_en_b) begin
            log_b[wr_n_b % 64] <= {3'b000, wr_addr_b, wr_data_b};
            wr_n_b <= wr_n_b + 1;
        end
        done_n_a  <= done_n_a + int'(done_a);
        done_n_b  <= done_n_b + int'(done_b);
        err_n_a   <= err_n_a + int'(err_a);
        err_n_b   <= err_n_b + int'(err_b);
        overlap_n <= overlap_n + int'((done_a && err_a) || (done_b && err_b));
    end

    int b_wr_a, b_wr_b, b_done_a, b_done_b, b_err_a, b_err_b;

    task automatic mark();
        b_wr_a = wr_n_a;     b_wr_b = wr_n_b;
        b_done_a = done_n_a; b_done_b = done_n_b;
        b_err_a = err_n_a;   b_err_b = err_n_b;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic brk);
        @(posedge clk);
        #1;
        rx_vld   = 1'b1;
        rx_d     = d;
        rx_break = brk;
        @(posedge clk);
        #1;
        rx_vld   = 1'b0;
        rx_break = 1'b0;
    endtask

    task automatic send_good();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h11, 1'b0);
    endtask

    initial begin
        #12;
        check_eq("rst_rx_en", 32'(rx_en_a), 32'd0);
        check_eq("rst_cmd", 32'(cmd_a), 32'd0);
        check_eq("rst_len", 32'(len_a), 32'd0);
        check_eq("rst_code", 32'(code_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        wait_cycles(2);
        enable = 1'b1;
        wait_cycles(2);
        check_eq("en_rx_en", 32'(rx_en_a), 32'd1);

        // Good frame: chk = 10^02^41^42 = 11
        mark();
        send_good();
        wait_cycles(2);
        check_eq("good_wr_n", 32'(wr_n_a - b_wr_a), 32'd2);
        check_eq("good_wr0", 32'(log_a[b_wr_a % 64]), 32'h0041);
        check_eq("good_wr1", 32'(log_a[(b_wr_a + 1) % 64]), 32'h0142);
        check_eq("good_done", 32'(done_n_a - b_done_a), 32'd1);
        check_eq("good_err", 32'(err_n_a - b_err_a), 32'd0);
        check_eq("good_cmd", 32'(cmd_a), 32'h10);
        check_eq("good_len", 32'(len_a), 32'd2);

        // Bad checksum with a different command: good chk would be 10
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h12, 1'b0);
        wait_cycles(2);
        check_eq("badchk_wr_n", 32'(wr_n_a - b_wr_a), 32'd2);
        check_eq("badchk_err", 32'(err_n_a - b_err_a), 32'd1);
        check_eq("badchk_done", 32'(done_n_a - b_done_a), 32'd0);
        check_eq("badchk_code", 32'(code_a), 32'd1);
        check_eq("badchk_cmd", 32'(cmd_a), 32'h10);
        check_eq("badchk_len", 32'(len_a), 32'd2);
        mark();
        send_good();
        wait_cycles(2);
        check_eq("after_bad_done", 32'(done_n_a - b_done_a), 32'd1);

        // Length 33 > 32
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h21, 1'b0);
        wait_cycles(2);
        check_eq("len_err", 32'(err_n_a - b_err_a), 32'd1);
        check_eq("len_code", 32'(code_a), 32'd2);
        check_eq("len_wr_n", 32'(wr_n_a - b_wr_a), 32'd0);

        // Zero-length frame: chk = 30^00 = 30
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        wait_cycles(2);
        check_eq("zlen_done", 32'(done_n_a - b_done_a), 32'd1);
        check_eq("zlen_len", 32'(len_a), 32'd0);
        check_eq("zlen_cmd", 32'(cmd_a), 32'h30);
        check_eq("zlen_wr_n", 32'(wr_n_a - b_wr_a), 32'd0);

        // Timeout after CMD byte (50-cycle limit in this bench)
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        wait_cycles(40);
        check_eq("tmo_busy_pre", 32'(busy_a), 32'd1);
        check_eq("tmo_err_pre", 32'(err_n_a - b_err_a), 32'd0);
        wait_cycles(20);
        check_eq("tmo_err", 32'(err_n_a - b_err_a), 32'd1);
        check_eq("tmo_code", 32'(code_a), 32'd3);
        check_eq("tmo_busy", 32'(busy_a), 32'd0);
        mark();
        send_good();
        wait_cycles(2);
        check_eq("tmo_restart_done", 32'(done_n_a - b_done_a), 32'd1);

        // Garbage before SYNC is ignored
        mark();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h13, 1'b0);
        send_good();
        wait_cycles(2);
        check_eq("hunt_done", 32'(done_n_a - b_done_a), 32'd1);
        check_eq("hunt_wr_n", 32'(wr_n_a - b_wr_a), 32'd2);
        check_eq("hunt_err", 32'(err_n_a - b_err_a), 32'd0);

        // Break on first DATA byte; non-break instance finishes with chk 10^02^00^42 = 50
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h42, 1'b0);
        send_byte(8'h50, 1'b0);
        wait_cycles(2);
        check_eq("brk_err", 32'(err_n_a - b_err_a), 32'd1);
        check_eq("brk_code", 32'(code_a), 32'd3);
        check_eq("brk_wr_n", 32'(wr_n_a - b_wr_a), 32'd0);
        check_eq("brk_done", 32'(done_n_a - b_done_a), 32'd0);
        check_eq("nobrk_wr_n", 32'(wr_n_b - b_wr_b), 32'd2);
        check_eq("nobrk_wr0", 32'(log_b[b_wr_b % 64]), 32'h0000);
        check_eq("nobrk_wr1", 32'(log_b[(b_wr_b + 1) % 64]), 32'h0142);
        check_eq("nobrk_done", 32'(done_n_b - b_done_b), 32'd1);
        check_eq("nobrk_err", 32'(err_n_b - b_err_b), 32'd0);

        // Enable dropped mid-DATA
        mark();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h41, 1'b0);
        enable = 1'b0;
        wait_cycles(3);
        check_eq("dis_rx_en", 32'(rx_en_a), 32'd0);
        check_eq("dis_busy", 32'(busy_a), 32'd0);
        check_eq("dis_wr_n", 32'(wr_n_a - b_wr_a), 32'd1);
        check_eq("dis_done", 32'(done_n_a - b_done_a), 32'd0);
        check_eq("dis_err", 32'(err_n_a - b_err_a), 32'd0);
        enable = 1'b1;
        mark();
        send_good();
        wait_cycles(2);
        check_eq("reen_done", 32'(done_n_a - b_done_a), 32'd1);

        // Asynchronous reset mid-frame, right while a write strobe is high
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h41, 1'b0);
        check_eq("pre_rst_wr_en", 32'(wr_en_a), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_wr_en", 32'(wr_en_a), 32'd0);
        check_eq("arst_wr_data", 32'(wr_data_a), 32'd0);
        check_eq("arst_cmd", 32'(cmd_a), 32'd0);
        check_eq("arst_len", 32'(len_a), 32'd0);
        check_eq("arst_code", 32'(code_a), 32'd0);
        check_eq("arst_busy", 32'(busy_a), 32'd0);
        check_eq("arst_rx_en", 32'(rx_en_a), 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);
        check_eq("no_overlap", 32'(overlap_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
